ifetch_single: RTL
==================

// Module: ifetch_single
// PURPOSE
//  Instruction fetch stage for the single-cycle MIPS core; sits directly upstream of the control decoder.
//  Owns the PC, fetches from an instruction memory with variable latency (req/ready), and holds the fetched word.
//  Presents the word and its opcode[31:26] to the decoder.
//  Applies PC+4 / branch-target / halt decisions once the datapath retires the current instruction.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] ignored (forced 0)
//  CNT_W      16             width of retired-instruction counter
// PORTS
//  clk          in   1   single core clock, rising edge
//  reset        in   1   asynchronous, active-high; clears all state
//  imem_addr    out  32  fetch address (= pc while imem_req=1)
//  imem_req     out  1   fetch request; held high until imem_ready
//  imem_rdata   in   32  instruction word, sampled when imem_req&imem_ready
//  imem_ready   in   1   memory completion strobe
//  instr        out  32  latched instruction word
//  opcode       out  6   instr[31:26], to control decoder
//  instr_valid  out  1   instr is valid and being executed
//  advance      in   1   datapath retires current instr this cycle (ignored unless instr_valid)
//  branch       in   1   decoder Branch for current instr
//  zero         in   1   ALU zero flag for current instr
//  halt         in   1   decoder Halt for current instr
//  pc           out  32  address of current instr
//  pc_plus4     out  32  pc + 4 (combinational, mod 2^32)
//  halted       out  1   core stopped (sticky until reset)
//  retired      out  CNT_W  retired-instruction count, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC&~3, instr=0, instr_valid=0, imem_req=0, halted=0,
//   retired=0, state=S_BOOT. Reset mid-fetch aborts the request; a late imem_ready is ignored.
//  FSM states S_BOOT, S_FETCH, S_EXEC, S_HALT:
//   S_BOOT : one cycle after reset release -> S_FETCH (imem_req rises 1 cycle after release).
//   S_FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, -> S_EXEC. Otherwise stay;
//            address stays stable. Zero-wait memory (ready same cycle as req) gives 1-cycle fetch.
//   S_EXEC : instr_valid=1, imem_req=0. On advance:
//            halt=1           -> S_HALT, pc unchanged, halted<=1, retired not incremented.
//            branch&zero      -> pc<=pc_plus4 + {sext(instr[15:0]),2'b00}, -> S_FETCH.
//            else             -> pc<=pc_plus4, -> S_FETCH.
//            Non-halt retire: retired<=retired+1, saturating at all-ones.
//            Without advance: hold all state; instr and opcode stable.
//   S_HALT : instr_valid=0, imem_req=0, halted=1; all inputs ignored until reset.
//  halt has priority over branch when both are set. halt/branch/zero are sampled only when
//   S_EXEC&advance; X on them outside that is harmless.
//  Arithmetic is 32-bit, wrap-around: 0xFFFF_FFFC+4=0. Branch offset is sign-extended; negative offsets wrap.
//  imem_ready in S_BOOT/S_EXEC/S_HALT is ignored. pc bits[1:0] are always 0.
//  Latency: issue to instr_valid = memory latency + 1 cycle; retire to next imem_req = 1 cycle.
// STRUCTURE
//  Shared package (mips_defs.vh): opcode constants (R_FORMAT=0, LW=35, SW=43, BEQ=4, HALT=63),
//   state encodings S_BOOT..S_HALT, INSTR_W=32.
//  One sub-module, pc_next_logic: combinational pc_plus4 and branch target from pc, instr[15:0],
//   branch, zero. FSM, registers and counter stay in ifetch_single.
// TESTING
//  1 Reset then zero-wait memory: imem_req at cycle 1 with addr 0; instr_valid at cycle 2; opcode=instr[31:26].
//  2 3-cycle memory, then advance with branch=0: imem_addr held at 0 for 3 cycles; next fetch addr 4; retired=1.
//  3 BEQ at pc=0x10 with imm=0xFFFE, branch=1, zero=1: next pc=0x0C. With zero=0: next pc=0x14.
//  4 HALT (opcode 63) with advance and branch=1: halted=1, pc stays; later imem_ready and advance: no change.
//  5 pc=0xFFFF_FFFC, advance with branch=0: next pc=0. Reset asserted mid-S_FETCH: imem_req drops at once,
//    pc=RESET_PC, stale ready ignored.
//  6 CNT_W=2: retire 5 non-halt instructions: retired saturates at 3. instr holds while advance=0.

Source files
------------

// File: rtl/ifetch_single_pkg.sv
// Shared definitions for the single-cycle MIPS fetch stage: opcodes, FSM states, word width.
package ifetch_single_pkg;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_R_FORMAT = 6'd0;
  localparam logic [5:0] OP_LW       = 6'd35;
  localparam logic [5:0] OP_SW       = 6'd43;
  localparam logic [5:0] OP_BEQ      = 6'd4;
  localparam logic [5:0] OP_HALT     = 6'd63;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;
endpackage

// File: rtl/ifetch_single_pc_next_logic.sv
// Combinational next-PC: sequential pc+4 or taken-branch target (pc+4 + sext(imm)<<2), wrapping.
module pc_next_logic
  import ifetch_single_pkg::*;
(
  input  logic [INSTR_W-1:0] i_pc,
  input  logic [15:0]        i_imm,
  input  logic               i_branch,
  input  logic               i_zero,
  output logic [INSTR_W-1:0] o_pc_plus4,
  output logic [INSTR_W-1:0] o_pc_next
);
  logic [INSTR_W-1:0] w_offset;
  logic [INSTR_W-1:0] w_target;

  assign o_pc_plus4 = i_pc + 32'd4;
  assign w_offset   = {{14{i_imm[15]}}, i_imm, 2'b00};
  assign w_target   = o_pc_plus4 + w_offset;
  assign o_pc_next  = (i_branch & i_zero) ? w_target : o_pc_plus4;
endmodule

// File: rtl/ifetch_single.sv
// Fetch stage: owns the PC, fetches over a req/ready memory port, holds the word for the decoder
// and applies the sequential / branch / halt decision when the datapath retires it.
module ifetch_single
  import ifetch_single_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       imem_addr,
  output logic              imem_req,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              advance,
  input  logic              branch,
  input  logic              zero,
  input  logic              halt,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);
  localparam logic [31:0] PC_RST = RESET_PC & ~32'd3;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        r_instr;
  logic [CNT_W-1:0]   r_retired;
  logic               w_ld_instr;
  logic               w_ld_pc;
  logic               w_inc_ret;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_pc_next;

  pc_next_logic u_pc_next (
    .i_pc       (r_pc),
    .i_imm      (r_instr[15:0]),
    .i_branch   (branch),
    .i_zero     (zero),
    .o_pc_plus4 (w_pc_plus4),
    .o_pc_next  (w_pc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_BOOT;
    else       r_state <= w_state_nxt;
  end

  // halt wins over branch; branch/zero only matter on a non-halt retire
  always_comb begin
    w_state_nxt = r_state;
    w_ld_instr  = 1'b0;
    w_ld_pc     = 1'b0;
    w_inc_ret   = 1'b0;
    case (r_state)
      S_BOOT:  w_state_nxt = S_FETCH;
      S_FETCH: if (imem_ready) begin
        w_ld_instr  = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC:  if (advance) begin
        if (halt) begin
          w_state_nxt = S_HALT;
        end else begin
          w_ld_pc     = 1'b1;
          w_inc_ret   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= PC_RST;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      if (w_ld_instr) r_instr <= imem_rdata;
      if (w_ld_pc)    r_pc    <= {w_pc_next[31:2], 2'b00};
      if (w_inc_ret && (r_retired != {CNT_W{1'b1}}))
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign instr_valid = (r_state == S_EXEC);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = (r_state == S_HALT);
  assign retired     = r_retired;
endmodule
